// File: rtl/lc3b_control.sv
// lc3b_control
// Multicycle Moore control FSM for the LC-3b mp0 datapath. It fetches,
// decodes and executes ADD, AND, NOT, BR, LDR and STR. It drives every
// datapath load enable and mux select, plus the memory strobes, and it
// waits on mem_resp during memory accesses. It also keeps a wrapping count
// of retired instructions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode              IR[15:12]
//   branch_enable       nzp compare result, sampled in BR
//   mem_resp            memory access complete
//   load_*              register load enables
//   *mux_sel            datapath mux selects
//   aluop               000 add, 001 and, 010 not, 011 pass-a
//   mem_read/mem_write  memory strobes
//   mem_byte_enable     always 2'b11 outside reset
//   instr_count         retired instruction counter
module lc3b_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           opcode,
  input  logic                 branch_enable,
  input  logic                 mem_resp,
  output logic                 load_pc,
  output logic                 load_ir,
  output logic                 load_regfile,
  output logic                 load_mar,
  output logic                 load_mdr,
  output logic                 load_cc,
  output logic                 pcmux_sel,
  output logic                 storemux_sel,
  output logic                 alumux_sel,
  output logic                 regfilemux_sel,
  output logic                 marmux_sel,
  output logic                 mdrmux_sel,
  output logic [2:0]           aluop,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           mem_byte_enable,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [3:0] FETCH1    = 4'd0;
  localparam logic [3:0] FETCH2    = 4'd1;
  localparam logic [3:0] FETCH3    = 4'd2;
  localparam logic [3:0] DECODE    = 4'd3;
  localparam logic [3:0] S_ADD     = 4'd4;
  localparam logic [3:0] S_AND     = 4'd5;
  localparam logic [3:0] S_NOT     = 4'd6;
  localparam logic [3:0] BR        = 4'd7;
  localparam logic [3:0] BR_TAKEN  = 4'd8;
  localparam logic [3:0] CALC_ADDR = 4'd9;
  localparam logic [3:0] LDR1      = 4'd10;
  localparam logic [3:0] LDR2      = 4'd11;
  localparam logic [3:0] STR1      = 4'd12;
  localparam logic [3:0] STR2      = 4'd13;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       retire;

  // Next-state selection. Memory states hold until mem_resp; any encoding
  // outside the defined set falls back to FETCH1.
  always_comb begin
    next_state = FETCH1;
    case (state)
      FETCH1:    next_state = FETCH2;
      FETCH2:    next_state = mem_resp ? FETCH3 : FETCH2;
      FETCH3:    next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:         next_state = S_ADD;
          OP_AND:         next_state = S_AND;
          OP_NOT:         next_state = S_NOT;
          OP_BR:          next_state = BR;
          OP_LDR, OP_STR: next_state = CALC_ADDR;
          default:        next_state = FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: next_state = FETCH1;
      BR:        next_state = branch_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN:  next_state = FETCH1;
      CALC_ADDR: begin
        if (opcode == OP_LDR)
          next_state = LDR1;
        else if (opcode == OP_STR)
          next_state = STR1;
        else
          next_state = FETCH1;
      end
      LDR1:      next_state = mem_resp ? LDR2 : LDR1;
      LDR2:      next_state = FETCH1;
      STR1:      next_state = STR2;
      STR2:      next_state = mem_resp ? FETCH1 : STR2;
      default:   next_state = FETCH1;
    endcase
  end

  // An instruction retires when a completing state hands control back to
  // FETCH1. Recovery from an illegal encoding does not count.
  always_comb begin
    retire = 1'b0;
    if (next_state == FETCH1) begin
      case (state)
        DECODE, S_ADD, S_AND, S_NOT, BR, BR_TAKEN, LDR2, STR2: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  // State register and retired-instruction counter; the counter wraps
  // naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH1;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire)
        instr_count <= instr_count + 1'b1;
    end
  end

  // Moore output decode. Everything is forced low while rst_n is low so a
  // reset in the middle of an access drops the strobes without a clock.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_cc         = 1'b0;
    pcmux_sel       = 1'b0;
    storemux_sel    = 1'b0;
    alumux_sel      = 1'b0;
    regfilemux_sel  = 1'b0;
    marmux_sel      = 1'b0;
    mdrmux_sel      = 1'b0;
    aluop           = 3'b000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    if (rst_n) begin
      mem_byte_enable = 2'b11;
      case (state)
        FETCH1: begin
          load_mar = 1'b1;
          load_pc  = 1'b1;
        end
        FETCH2, LDR1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        S_ADD, S_AND, S_NOT: begin
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          if (state == S_AND)
            aluop = 3'b001;
          else if (state == S_NOT)
            aluop = 3'b010;
          else
            aluop = 3'b000;
        end
        BR_TAKEN: begin
          pcmux_sel = 1'b1;
          load_pc   = 1'b1;
        end
        CALC_ADDR: begin
          alumux_sel = 1'b1;
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
        end
        LDR2: begin
          regfilemux_sel = 1'b1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        STR1: begin
          storemux_sel = 1'b1;
          aluop        = 3'b011;
          mdrmux_sel   = 1'b1;
          load_mdr     = 1'b1;
        end
        STR2: mem_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_control.sv
// tb_lc3b_control
// Directed bench for lc3b_control built with a 4-bit counter so the wrap
// is quick to reach. Each vector row gives the inputs for one cycle and the
// outputs expected in that cycle; hand-written sequences cover the
// asynchronous reset and the counter wrap.
module tb_lc3b_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel;
  logic       marmux_sel, mdrmux_sel;
  logic [2:0] aluop;
  logic       mem_read, mem_write;
  logic [1:0] mem_byte_enable;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  // Expected output patterns, packed as
  // {lpc,lir,lrf,lmar,lmdr,lcc}_{pcm,stm,alum,rfm,marm,mdrm}_{aluop}_{rd,wr}
  localparam logic [16:0] E_F1   = 17'b100100_000000_000_00;
  localparam logic [16:0] E_F2   = 17'b000010_000000_000_10;
  localparam logic [16:0] E_F3   = 17'b010000_000000_000_00;
  localparam logic [16:0] E_DEC  = 17'b000000_000000_000_00;
  localparam logic [16:0] E_ADD  = 17'b001001_000000_000_00;
  localparam logic [16:0] E_AND  = 17'b001001_000000_001_00;
  localparam logic [16:0] E_NOT  = 17'b001001_000000_010_00;
  localparam logic [16:0] E_BR   = 17'b000000_000000_000_00;
  localparam logic [16:0] E_BRT  = 17'b100000_100000_000_00;
  localparam logic [16:0] E_CALC = 17'b000100_001010_000_00;
  localparam logic [16:0] E_LDR1 = 17'b000010_000000_000_10;
  localparam logic [16:0] E_LDR2 = 17'b001001_000100_000_00;
  localparam logic [16:0] E_STR1 = 17'b000010_010001_011_00;
  localparam logic [16:0] E_STR2 = 17'b000000_000000_000_01;
  localparam logic [16:0] E_OFF  = 17'b000000_000000_000_00;

  typedef struct {
    logic [3:0]  op;
    logic        be;
    logic        resp;
    logic [16:0] exp;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs [0:63];
  int   nvec = 0;

  logic [16:0] actual;
  assign actual = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                   pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel,
                   marmux_sel, mdrmux_sel, aluop, mem_read, mem_write};

  lc3b_control #(.CNT_WIDTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .branch_enable   (branch_enable),
    .mem_resp        (mem_resp),
    .load_pc         (load_pc),
    .load_ir         (load_ir),
    .load_regfile    (load_regfile),
    .load_mar        (load_mar),
    .load_mdr        (load_mdr),
    .load_cc         (load_cc),
    .pcmux_sel       (pcmux_sel),
    .storemux_sel    (storemux_sel),
    .alumux_sel      (alumux_sel),
    .regfilemux_sel  (regfilemux_sel),
    .marmux_sel      (marmux_sel),
    .mdrmux_sel      (mdrmux_sel),
    .aluop           (aluop),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .instr_count     (instr_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case the run stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addRow(input logic [3:0] op, input logic be, input logic resp,
                        input logic [16:0] exp, input logic [3:0] cnt);
    vecs[nvec] = '{op: op, be: be, resp: resp, exp: exp, cnt: cnt};
    nvec++;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic be, input logic resp);
    opcode        = op;
    branch_enable = be;
    mem_resp      = resp;
  endtask

  task automatic checkOutput(input string name, input logic [16:0] exp,
                             input logic [3:0] cnt);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %b required %b", name, actual, exp);
    end
    checks++;
    if (instr_count !== cnt) begin
      errors++;
      $display("[TB] FAIL %s instr_count: got %0d required %0d", name, instr_count, cnt);
    end
    if (exp[0]) begin
      checks++;
      if (mem_byte_enable !== 2'b11) begin
        errors++;
        $display("[TB] FAIL %s mem_byte_enable: got %b required 11", name, mem_byte_enable);
      end
    end
  endtask

  // Main sequence: vector table, then async reset mid-fetch, then wrap.
  initial begin
    logic [3:0] model_cnt;

    // ADD, zero-wait
    addRow(4'h1, 0, 0, E_F1,  0); addRow(4'h1, 0, 1, E_F2,  0);
    addRow(4'h1, 0, 0, E_F3,  0); addRow(4'h1, 0, 0, E_DEC, 0);
    addRow(4'h1, 0, 0, E_ADD, 0);
    // AND, stray mem_resp in FETCH3 has no effect
    addRow(4'h5, 0, 0, E_F1,  1); addRow(4'h5, 0, 1, E_F2,  1);
    addRow(4'h5, 0, 1, E_F3,  1); addRow(4'h5, 0, 0, E_DEC, 1);
    addRow(4'h5, 0, 0, E_AND, 1);
    // NOT
    addRow(4'h9, 0, 0, E_F1,  2); addRow(4'h9, 0, 1, E_F2,  2);
    addRow(4'h9, 0, 0, E_F3,  2); addRow(4'h9, 0, 0, E_DEC, 2);
    addRow(4'h9, 0, 0, E_NOT, 2);
    // BR not taken: branch_enable high in DECODE only, low in BR
    addRow(4'h0, 0, 0, E_F1,  3); addRow(4'h0, 0, 1, E_F2,  3);
    addRow(4'h0, 0, 0, E_F3,  3); addRow(4'h0, 1, 0, E_DEC, 3);
    addRow(4'h0, 0, 1, E_BR,  3);
    // BR taken
    addRow(4'h0, 0, 0, E_F1,  4); addRow(4'h0, 0, 1, E_F2,  4);
    addRow(4'h0, 0, 0, E_F3,  4); addRow(4'h0, 0, 0, E_DEC, 4);
    addRow(4'h0, 1, 0, E_BR,  4); addRow(4'h0, 0, 0, E_BRT, 4);
    // LDR with one wait state in LDR1
    addRow(4'h6, 0, 0, E_F1,   5); addRow(4'h6, 0, 1, E_F2,   5);
    addRow(4'h6, 0, 0, E_F3,   5); addRow(4'h6, 0, 0, E_DEC,  5);
    addRow(4'h6, 0, 0, E_CALC, 5); addRow(4'h6, 0, 0, E_LDR1, 5);
    addRow(4'h6, 0, 1, E_LDR1, 5); addRow(4'h6, 0, 0, E_LDR2, 5);
    // STR with one wait state in STR2, stray mem_resp in STR1
    addRow(4'h7, 0, 0, E_F1,   6); addRow(4'h7, 0, 1, E_F2,   6);
    addRow(4'h7, 0, 0, E_F3,   6); addRow(4'h7, 0, 0, E_DEC,  6);
    addRow(4'h7, 0, 0, E_CALC, 6); addRow(4'h7, 0, 1, E_STR1, 6);
    addRow(4'h7, 0, 0, E_STR2, 6); addRow(4'h7, 0, 1, E_STR2, 6);
    // Illegal opcode retires as a NOP straight from DECODE
    addRow(4'hF, 0, 0, E_F1,  7); addRow(4'hF, 0, 1, E_F2,  7);
    addRow(4'hF, 0, 0, E_F3,  7); addRow(4'hF, 0, 0, E_DEC, 7);
    // ADD with three fetch wait states
    addRow(4'h1, 0, 0, E_F1,  8); addRow(4'h1, 0, 0, E_F2,  8);
    addRow(4'h1, 0, 0, E_F2,  8); addRow(4'h1, 0, 0, E_F2,  8);
    addRow(4'h1, 0, 1, E_F2,  8); addRow(4'h1, 0, 0, E_F3,  8);
    addRow(4'h1, 0, 0, E_DEC, 8); addRow(4'h1, 0, 0, E_ADD, 8);

    // Reset from time zero with inputs idle
    rst_n = 1'b0;
    applyStimulus(4'h0, 0, 0);
    #1;
    checks++;
    if (actual !== E_OFF || mem_byte_enable !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b/%b required all zero", actual, mem_byte_enable);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < nvec; i++) begin
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cnt);
      applyStimulus(vecs[i].op, vecs[i].be, vecs[i].resp);
      @(negedge clk);
    end

    // Reset in the middle of a fetch read
    checkOutput("pre_reset_f1", E_F1, 9);
    applyStimulus(4'h1, 0, 0);
    @(negedge clk);
    checkOutput("pre_reset_f2", E_F2, 9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_access", E_OFF, 0);
    checks++;
    if (mem_byte_enable !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_byte_enable: got %b required 00", mem_byte_enable);
    end
    mem_resp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_f1", E_F1, 0);
    applyStimulus(4'hF, 0, 1);
    @(negedge clk);
    checkOutput("post_reset_f2", E_F2, 0);

    // Finish one NOP, then keep retiring NOPs until the counter wraps
    @(negedge clk);
    checkOutput("post_reset_f3", E_F3, 0);
    applyStimulus(4'hF, 0, 0);
    @(negedge clk);
    checkOutput("post_reset_dec", E_DEC, 0);
    @(negedge clk);
    model_cnt = 4'd1;
    checkOutput("nop_retire", E_F1, model_cnt);
    for (int n = 0; n < 15; n++) begin
      applyStimulus(4'hF, 0, 0);
      @(negedge clk);
      applyStimulus(4'hF, 0, 1);
      @(negedge clk);
      applyStimulus(4'hF, 0, 0);
      @(negedge clk);
      @(negedge clk);
      model_cnt = model_cnt + 4'd1;
    end
    checkOutput("count_wrap", E_F1, 4'd0);
    checks++;
    if (model_cnt !== instr_count) begin
      errors++;
      $display("[TB] FAIL wrap_model: got %0d required %0d", instr_count, model_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
